// File: rtl/sub_result_if.sv
// Handshake bundle between the subtractor, sub_result_stage and the result mux.
// master: the side that drives operands and out_ready; slave: sub_result_stage.
interface sub_result_if #(
  parameter int unsigned W     = 10,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W:0]       in_diff;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       out_res;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;
  logic             out_chk;
  logic [CNT_W-1:0] res_cnt;

  modport master (
    output in_valid, in_a, in_b, in_diff, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_neg, out_ovf, out_chk, res_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_diff, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_neg, out_ovf, out_chk, res_cnt
  );
endinterface

// File: rtl/sub_result_stage.sv
// Registered result stage after the ripple subtractor: 2-entry skid buffer, borrow/status flags,
// delivered-result counter. Optional sticky overflow flag enabled by macro SUB_STICKY_OVF_EN.
module sub_result_stage #(
  parameter int unsigned W     = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_result_if.slave  bus
`ifdef SUB_STICKY_OVF_EN
  ,
  input  logic         ovf_clr,
  output logic         ovf_sticky
`endif
);

  typedef struct packed {
    logic [W:0] res;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       chk;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e           state_q, state_d;
  entry_t           main_q, skid_q, cap_c;
  logic             in_ready_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c, deliver_c;
  logic             load_main_c, load_skid_c, pop_skid_c;
  logic [W-1:0]     diff_ref_c;
  logic             unused_diff_msb;

  // The subtractor's carry-out bit carries no meaning here.
  assign unused_diff_msb = bus.in_diff[W];

  assign diff_ref_c = bus.in_a - bus.in_b;
  assign accept_c   = bus.in_valid && in_ready_q;
  assign deliver_c  = out_valid_q && bus.out_ready;

  // Flags are frozen at capture and travel with the entry.
  always_comb begin
    cap_c.res  = {W'(0) == W'(0) && (bus.in_a < bus.in_b), bus.in_diff[W-1:0]};
    cap_c.zero = (bus.in_diff[W-1:0] == W'(0));
    cap_c.neg  = bus.in_diff[W-1];
    cap_c.ovf  = (bus.in_a[W-1] != bus.in_b[W-1]) && (bus.in_diff[W-1] != bus.in_a[W-1]);
    cap_c.chk  = (bus.in_diff[W-1:0] != diff_ref_c);
  end

  always_comb begin
    state_d     = state_q;
    load_main_c = 1'b0;
    load_skid_c = 1'b0;
    pop_skid_c  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          load_main_c = 1'b1;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept_c && deliver_c) begin
          load_main_c = 1'b1;
        end else if (accept_c) begin
          load_skid_c = 1'b1;
          state_d     = FULL;
        end else if (deliver_c) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (deliver_c) begin
          pop_skid_c = 1'b1;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (load_main_c)      main_q <= cap_c;
      else if (pop_skid_c)  main_q <= skid_q;
      if (load_skid_c)      skid_q <= cap_c;
      if (deliver_c)        cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SUB_STICKY_OVF_EN
  logic sticky_q;

  // Set takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sticky_q <= 1'b0;
    else if (deliver_c && main_q.ovf) sticky_q <= 1'b1;
    else if (ovf_clr)                sticky_q <= 1'b0;
  end

  assign ovf_sticky = sticky_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = main_q.res;
  assign bus.out_zero  = main_q.zero;
  assign bus.out_neg   = main_q.neg;
  assign bus.out_ovf   = main_q.ovf;
  assign bus.out_chk   = main_q.chk;
  assign bus.res_cnt   = cnt_q;

endmodule

// File: tb/tb_sub_result_stage.sv
// Scoreboard bench for sub_result_stage: directed flag cases, backpressure, random traffic,
// counter wrap and mid-stream reset. Define SUB_STICKY_OVF_EN to also cover the sticky flag.
module tb_sub_result_stage;
  localparam int unsigned W     = 10;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [W:0] res;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       chk;
  } exp_t;

  logic clk;
  logic rst_n;
`ifdef SUB_STICKY_OVF_EN
  logic ovf_clr;
  logic ovf_sticky;
`endif

  sub_result_if #(.W(W), .CNT_W(CNT_W)) bus ();

  sub_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SUB_STICKY_OVF_EN
    ,
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  exp_t             sb_q[$];
  logic [CNT_W-1:0] cnt_model = '0;
  logic             hold_v = 1'b0;
  logic [W:0]       hold_res = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] d);
    exp_t       e;
    logic [W:0] wide;
    wide   = {1'b0, a} - {1'b0, b};
    e.res  = {wide[W], d[W-1:0]};
    e.zero = (d[W-1:0] == W'(0));
    e.neg  = d[W-1];
    e.ovf  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    e.chk  = (d[W-1:0] != wide[W-1:0]);
    return e;
  endfunction

  // Called at a negedge; drives one cycle, scores the edge, returns at the next negedge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W:0] d, input logic rdy, output logic acc);
    exp_t e;
    if (hold_v) check_eq("hold_stable", 32'(bus.out_res), 32'(hold_res));
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_diff   = d;
    bus.out_ready = rdy;
    check_eq("res_cnt", 32'(bus.res_cnt), 32'(cnt_model));
    if (bus.out_valid && rdy) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("out_res",  32'(bus.out_res),  32'(e.res));
        check_eq("out_zero", 32'(bus.out_zero), 32'(e.zero));
        check_eq("out_neg",  32'(bus.out_neg),  32'(e.neg));
        check_eq("out_ovf",  32'(bus.out_ovf),  32'(e.ovf));
        check_eq("out_chk",  32'(bus.out_chk),  32'(e.chk));
      end
      cnt_model = cnt_model + CNT_W'(1);
    end
    hold_v   = bus.out_valid && !rdy;
    hold_res = bus.out_res;
    acc = v && bus.in_ready;
    if (acc) sb_q.push_back(model(a, b, d));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_step(input int unsigned v_pct, input int unsigned r_pct, output logic acc);
    logic [W-1:0] a, b, dd;
    a  = W'($urandom);
    b  = W'($urandom);
    dd = a - b;
    if ($urandom_range(7) == 0) dd = dd ^ W'(1 << $urandom_range(W - 1));
    step($urandom_range(99) < v_pct, a, b, {1'($urandom), dd}, $urandom_range(99) < r_pct, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 8 && (sb_q.size() != 0 || bus.out_valid); i++)
      step(1'b0, '0, '0, '0, 1'b1, acc);
    check_eq("drained", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'(1));
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    check_eq({tag, "_res_cnt"},   32'(bus.res_cnt),   32'(0));
    check_eq({tag, "_out_res"},   32'(bus.out_res),   32'(0));
`ifdef SUB_STICKY_OVF_EN
    check_eq({tag, "_sticky"},    32'(ovf_sticky),    32'(0));
`endif
  endtask

  // Asserts reset off-edge, checks the cleared state, releases at a negedge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_state(tag);
    sb_q.delete();
    cnt_model = '0;
    hold_v    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [W:0] res, input logic z,
                           input logic n, input logic o, input logic c);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
    check_eq({tag, "_res"},   32'(bus.out_res),   32'(res));
    check_eq({tag, "_zero"},  32'(bus.out_zero),  32'(z));
    check_eq({tag, "_neg"},   32'(bus.out_neg),   32'(n));
    check_eq({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
    check_eq({tag, "_chk"},   32'(bus.out_chk),   32'(c));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   sent;
    int   guard;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_diff   = '0;
    bus.out_ready = 1'b0;
`ifdef SUB_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed flag cases, one-cycle latency
    step(1'b1, 10'd300, 10'd100, 11'd200, 1'b1, acc);
    check_out("t2", 11'h0C8, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd5, 10'd10, 11'h3FB, 1'b1, acc);
    check_out("t3", 11'h7FB, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'h1FF, 10'h200, 11'h3FF, 1'b1, acc);
    check_out("t4", 11'h7FF, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd7, 10'd7, 11'd1, 1'b1, acc);
    check_out("t5", 11'h001, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SUB_STICKY_OVF_EN
    check_eq("sticky_set", 32'(ovf_sticky), 32'(1));
    step(1'b0, '0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    check_eq("sticky_hold", 32'(ovf_sticky), 32'(1));
    ovf_clr = 1'b1;
    step(1'b0, '0, '0, '0, 1'b1, acc);
    ovf_clr = 1'b0;
    check_eq("sticky_clr", 32'(ovf_sticky), 32'(0));
`endif
    drain();

    // Backpressure: third word must be held off until the skid entry drains
    do_reset("bp_reset");
    step(1'b1, 10'd40, 10'd1, 11'd39, 1'b0, acc);
    check_eq("bp_ready_w1", 32'(bus.in_ready), 32'(1));
    step(1'b1, 10'd41, 10'd2, 11'd39, 1'b0, acc);
    check_eq("bp_ready_w2", 32'(bus.in_ready), 32'(0));
    step(1'b1, 10'd42, 10'd50, 11'h3F8, 1'b0, acc);
    check_eq("bp_w3_held_off", 32'(acc), 32'(0));
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, 10'd42, 10'd50, 11'h3F8, 1'b1, acc);
    check_eq("bp_w3_accepted", 32'(acc), 32'(1));
    drain();
    check_eq("bp_res_cnt", 32'(bus.res_cnt), 32'(3));

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) rand_step(70, 60, acc);
    drain();

    // Counter wrap at full throughput
    do_reset("wrap_reset");
    sent  = 0;
    guard = 0;
    while (sent < 65536 && guard < 70000) begin
      rand_step(100, 100, acc);
      if (acc) sent++;
      guard++;
    end
    check_eq("wrap_sent", 32'(sent), 32'(65536));
    drain();
    check_eq("wrap_res_cnt", 32'(bus.res_cnt), 32'(0));

    // Reset in the middle of a stream
    for (int i = 0; i < 20; i++) rand_step(100, 100, acc);
    do_reset("mid_reset");
    step(1'b1, 10'd9, 10'd3, 11'd6, 1'b1, acc);
    check_out("post_reset", 11'h006, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check_eq("post_reset_cnt", 32'(bus.res_cnt), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
